mnist_window_gen: RTL and testbench

- Upstream feeder for the simpleCNN core.
- Accepts one 28x28 8-bit MNIST image as a raster pixel stream and stores it in an internal frame buffer.
- Scans every 5x5 window position (24x24 = 576 windows) and presents each as a packed 200-bit IMGIN word with its X/Y coordinates, using a valid/ready handshake.
- Replaces the bench-side window extraction so the CNN can be driven by a real pixel source.

---
 rtl/mnist_window_gen.sv | 141 ++++++++++++++
 tb/tb_mnist_window_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mnist_window_gen.sv
// Raster pixel loader and 5x5 sliding-window generator feeding the simpleCNN core.
// Buffers one IMG_H x IMG_W frame, then streams every KxK window over a valid/ready handshake.
module mnist_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int PW    = 8,
  parameter int CW    = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PIX_VALID,
  input  logic [PW-1:0]       PIX_DATA,
  output logic                PIX_READY,
  output logic                WIN_VALID,
  input  logic                WIN_READY,
  output logic [K*K*PW-1:0]   IMGIN,
  output logic [CW-1:0]       X,
  output logic [CW-1:0]       Y,
  output logic                WIN_LAST,
  output logic [7:0]          FRAME_CNT
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam logic [CW-1:0] XMAX = CW'(IMG_H - K);
  localparam logic [CW-1:0] YMAX = CW'(IMG_W - K);

  typedef enum logic {S_LOAD, S_SCAN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PW-1:0]       r_mem [NPIX];
  logic [AW-1:0]       r_cnt;
  logic                r_valid;
  logic                r_last;
  logic [CW-1:0]       r_x;
  logic [CW-1:0]       r_y;
  logic [K*K*PW-1:0]   r_win;
  logic [7:0]          r_fcnt;

  logic                w_pix_fire;
  logic                w_adv;
  logic                w_done;
  logic [CW-1:0]       w_nx;
  logic [CW-1:0]       w_ny;
  logic [AW-1:0]       w_base;
  logic [K*K*PW-1:0]   w_win;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pix_fire   = 1'b0;
    w_adv        = 1'b0;
    w_done       = 1'b0;
    w_nx         = '0;
    w_ny         = '0;
    PIX_READY    = 1'b0;
    case (r_state)
      S_LOAD: begin
        PIX_READY  = 1'b1;
        w_pix_fire = PIX_VALID;
        if (PIX_VALID && r_cnt == AW'(NPIX - 1)) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        // No window held yet means this is the first SCAN cycle: load (0,0).
        if (!r_valid) begin
          w_adv = 1'b1;
        end else if (WIN_READY) begin
          if (r_last) begin
            w_done       = 1'b1;
            w_state_next = S_LOAD;
          end else begin
            w_adv = 1'b1;
            if (r_y == YMAX) begin
              w_nx = r_x + CW'(1);
            end else begin
              w_nx = r_x;
              w_ny = r_y + CW'(1);
            end
          end
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  // Gather the window for the next coordinates so it registers on the advancing edge.
  always_comb begin
    w_base = AW'(w_nx) * AW'(IMG_W) + AW'(w_ny);
    w_win  = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        w_win[(i*K + j)*PW +: PW] = r_mem[w_base + AW'(i*IMG_W + j)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_pix_fire) r_mem[r_cnt] <= PIX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_win   <= '0;
      r_fcnt  <= '0;
    end else begin
      if (w_pix_fire) r_cnt <= (r_cnt == AW'(NPIX - 1)) ? '0 : r_cnt + AW'(1);
      if (w_adv) begin
        r_valid <= 1'b1;
        r_x     <= w_nx;
        r_y     <= w_ny;
        r_win   <= w_win;
        r_last  <= (w_nx == XMAX) && (w_ny == YMAX);
      end else if (w_done) begin
        r_valid <= 1'b0;
        r_x     <= '0;
        r_y     <= '0;
        r_last  <= 1'b0;
        r_fcnt  <= r_fcnt + 8'd1;
      end
    end
  end

  assign WIN_VALID = r_valid;
  assign WIN_LAST  = r_last;
  assign X         = r_x;
  assign Y         = r_y;
  assign IMGIN     = r_win;
  assign FRAME_CNT = r_fcnt;

endmodule

// File: tb/tb_mnist_window_gen.sv
// Scoreboard bench for mnist_window_gen: reference windows are cut from a bench-side image array.
module tb_mnist_window_gen;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int K  = 5;
  localparam int NP = W * H;
  localparam int NW = W - K + 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PIX_VALID;
  logic [7:0]   PIX_DATA;
  logic         PIX_READY;
  logic         WIN_VALID;
  logic         WIN_READY;
  logic [199:0] IMGIN;
  logic [4:0]   X;
  logic [4:0]   Y;
  logic         WIN_LAST;
  logic [7:0]   FRAME_CNT;

  always #5 CLK = ~CLK;

  mnist_window_gen #(.IMG_W(28), .IMG_H(28), .K(5), .PW(8), .CW(5)) dut (
    .CLK(CLK), .RST(RST),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY),
    .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY), .IMGIN(IMGIN),
    .X(X), .Y(Y), .WIN_LAST(WIN_LAST), .FRAME_CNT(FRAME_CNT)
  );

  typedef struct {
    logic [4:0]   x;
    logic [4:0]   y;
    logic         last;
    logic [199:0] img;
  } win_t;

  win_t       sb_q[$];
  logic [7:0] img [NP];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic         prev_hold = 1'b0;
  logic [211:0] prev_word;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic make_image(input int kind);
    for (int p = 0; p < NP; p++) begin
      case (kind)
        0:       img[p] = 8'(p);
        1:       img[p] = 8'hA5;
        default: img[p] = 8'($urandom);
      endcase
    end
  endtask

  task automatic push_frame();
    win_t w;
    for (int x = 0; x < NW; x++) begin
      for (int y = 0; y < NW; y++) begin
        w.x    = 5'(x);
        w.y    = 5'(y);
        w.last = (x == NW-1) && (y == NW-1);
        w.img  = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            w.img[(i*K + j)*8 +: 8] = img[(x+i)*W + (y+j)];
        sb_q.push_back(w);
      end
    end
  endtask

  task automatic load_frame(input bit bursty);
    int p = 0;
    int guard = 0;
    while (p < NP && guard < 20000) begin
      @(posedge CLK); #1;
      guard++;
      if (bursty && $urandom_range(1, 0) == 0) begin
        PIX_VALID = 1'b0;
        PIX_DATA  = 8'($urandom);
      end else begin
        PIX_VALID = 1'b1;
        PIX_DATA  = img[p];
        if (PIX_READY) p++;
      end
    end
    if (p < NP) chk("load_timeout", p, NP);
    @(posedge CLK); #1;
    PIX_VALID = 1'b0;
    chk("ready_drop", {WIN_VALID, PIX_READY}, 2'b00);
    push_frame();
  endtask

  // mode 0: ready high, 1: 7-cycle stall on (0,5), 2: random ready, 3: reset at (10,3)
  task automatic scan_frame(input int mode, input bit ramp_chk, input bit hold_pix, input logic [7:0] exp_fc);
    int guard = 0;
    int nvalid = 0;
    int stall = 0;
    bit done = 0;
    WIN_READY = (mode == 0);
    if (hold_pix) PIX_VALID = 1'b1;
    while (!done && guard < 20000) begin
      @(posedge CLK); #1;
      guard++;
      if (hold_pix) PIX_DATA = 8'($urandom);
      if (ramp_chk && guard == 1)
        chk("first_window", {WIN_VALID, X, Y, IMGIN[7:0], IMGIN[39:32], IMGIN[47:40], IMGIN[199:192]},
            {1'b1, 5'd0, 5'd0, 8'h00, 8'h04, 8'h1C, 8'h74});
      if (ramp_chk && WIN_LAST)
        chk("last_window", {X, Y, IMGIN[7:0], IMGIN[199:192]}, {5'd23, 5'd23, 8'h9B, 8'h0F});
      if (WIN_VALID) nvalid++;
      if (mode == 3 && WIN_VALID && X == 5'd10 && Y == 5'd3) begin
        RST = 1'b1;
        WIN_READY = 1'b0;
        @(posedge CLK); #1;
        chk("reset_mid_scan", {WIN_VALID, PIX_READY, FRAME_CNT, X, Y}, {1'b0, 1'b1, 8'd0, 5'd0, 5'd0});
        RST = 1'b0;
        sb_q.delete();
        PIX_VALID = 1'b0;
        return;
      end
      if (sb_q.size() == 0) begin
        done = 1;
      end else begin
        case (mode)
          1: begin
            WIN_READY = !(WIN_VALID && X == 5'd0 && Y == 5'd5 && stall < 7);
            if (!WIN_READY) stall++;
          end
          2, 3: WIN_READY = 1'($urandom_range(1, 0));
          default: WIN_READY = 1'b1;
        endcase
      end
    end
    PIX_VALID = 1'b0;
    WIN_READY = 1'b0;
    if (!done) chk("scan_timeout", done, 1'b1);
    chk("frame_end", {WIN_VALID, PIX_READY, X, Y, FRAME_CNT}, {1'b0, 1'b1, 5'd0, 5'd0, exp_fc});
    if (mode == 0) chk("valid_cycles", nvalid, NW*NW);
    if (mode == 1) chk("stall_seen", stall, 7);
  endtask

  always @(negedge CLK) begin
    win_t e;
    if (RST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {WIN_VALID, WIN_LAST, X, Y, IMGIN}, prev_word);
      if (WIN_VALID && WIN_READY) begin
        if (sb_q.size() == 0) begin
          chk("extra_window", WIN_VALID, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("window", {WIN_LAST, X, Y, IMGIN}, {e.last, e.x, e.y, e.img});
        end
      end
      prev_hold = WIN_VALID && !WIN_READY;
      prev_word = {WIN_VALID, WIN_LAST, X, Y, IMGIN};
    end
  end

  initial begin
    RST = 1'b1;
    PIX_VALID = 1'b0;
    PIX_DATA = '0;
    WIN_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", {PIX_READY, WIN_VALID, WIN_LAST, X, Y, FRAME_CNT},
        {1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'd0});
    chk("reset_imgin", IMGIN, 200'd0);
    RST = 1'b0;

    make_image(0); load_frame(0); scan_frame(0, 1, 0, 8'd1);
    load_frame(0); scan_frame(1, 0, 0, 8'd2);
    load_frame(1); scan_frame(2, 0, 1, 8'd3);
    make_image(2); load_frame(0); scan_frame(3, 0, 0, 8'd0);
    make_image(0); load_frame(0); scan_frame(0, 1, 0, 8'd1);
    make_image(1); load_frame(1); scan_frame(2, 0, 0, 8'd2);
    chk("queue_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
